branch_predict_unit: RTL and testbench

//  Parametrised next-generation branch unit: resolves branches/jumps in EX, same brOP encoding as the

---
 rtl/branch_predict_unit.sv | 202 ++++++++++++++++++++
 tb/tb_branch_predict_unit.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predict_unit.sv
// Branch resolution in EX plus a direct-mapped BTB with saturating direction counters for IF prediction.
// Optional performance counters are enabled with the BPU_PERF_CNT_EN macro.
module branch_predict_unit #(
    parameter int ENTRIES  = 16,
    parameter int CTR_BITS = 2,
    parameter int PC_W     = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
`ifdef BPU_PERF_CNT_EN
    output logic [31:0]     o_bpu_br_cnt,
    output logic [31:0]     o_bpu_miss_cnt,
`endif
    input  logic [PC_W-1:0] i_bpu_if_pc,
    output logic            o_bpu_pred_taken,
    output logic [PC_W-1:0] o_bpu_pred_target,
    input  logic            i_bpu_valid,
    input  logic [3:0]      i_bpu_brOP,
    input  logic [PC_W-1:0] i_bpu_A,
    input  logic [PC_W-1:0] i_bpu_B,
    input  logic [25:0]     i_bpu_target,
    input  logic [PC_W-1:0] i_bpu_ex_pc,
    input  logic [PC_W-1:0] i_bpu_ex_pcnext,
    input  logic            i_bpu_ex_pred_taken,
    input  logic [PC_W-1:0] i_bpu_ex_pred_target,
    output logic            o_bpu_redirect,
    output logic [PC_W-1:0] o_bpu_redirect_PC,
    output logic            o_bpu_clr
);

    localparam int IDX   = $clog2(ENTRIES);
    localparam int TAG_W = PC_W - IDX - 2;

    localparam logic [CTR_BITS-1:0] CTR_WEAK_NT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
    localparam logic [CTR_BITS-1:0] CTR_WEAK_T  = CTR_BITS'(1 << (CTR_BITS - 1));
    localparam logic [CTR_BITS-1:0] CTR_MAX     = '1;

    typedef enum logic [3:0] {
        OP_NONE   = 4'd0,  OP_JR    = 4'd1,  OP_J     = 4'd2,  OP_JAL   = 4'd3,
        OP_BAL    = 4'd4,  OP_BGEZAL = 4'd5, OP_BLTZ  = 4'd6,  OP_BGEZ  = 4'd7,
        OP_BLTZAL = 4'd8,  OP_B     = 4'd9,  OP_BEQ   = 4'd10, OP_BNE   = 4'd11,
        OP_BLEZ   = 4'd12, OP_BGTZ  = 4'd13, OP_RSV14 = 4'd14, OP_RSV15 = 4'd15
    } br_op_e;

    typedef enum logic [1:0] {TGT_BRANCH, TGT_JUMP, TGT_REG} tgt_sel_e;

    // BTB storage
    logic                valid_q [ENTRIES];
    logic [TAG_W-1:0]    tag_q   [ENTRIES];
    logic [PC_W-1:0]     tgt_q   [ENTRIES];
    logic [CTR_BITS-1:0] ctr_q   [ENTRIES];

    logic            redirect_q;
    logic [PC_W-1:0] redirect_pc_q;

    // IF-side lookup reads the arrays directly, so a same-cycle update is not visible yet.
    logic [IDX-1:0]   if_idx;
    logic [TAG_W-1:0] if_tag;
    logic             if_hit;

    assign if_idx = i_bpu_if_pc[IDX+1:2];
    assign if_tag = i_bpu_if_pc[PC_W-1:IDX+2];
    assign if_hit = valid_q[if_idx] && (tag_q[if_idx] == if_tag);

    assign o_bpu_pred_taken  = if_hit && ctr_q[if_idx][CTR_BITS-1];
    assign o_bpu_pred_target = o_bpu_pred_taken ? tgt_q[if_idx] : '0;

    // EX-side decode
    br_op_e   op;
    tgt_sel_e tgt_sel;
    logic     is_branch;
    logic     cond;
    logic     a_neg;
    logic     a_zero;

    assign op     = br_op_e'(i_bpu_brOP);
    assign a_neg  = i_bpu_A[PC_W-1];
    assign a_zero = (i_bpu_A == '0);

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        is_branch = 1'b0;
        cond      = 1'b0;
        tgt_sel   = TGT_BRANCH;
        case (op)
            OP_JR:               begin is_branch = 1'b1; cond = 1'b1; tgt_sel = TGT_REG;  end
            OP_J, OP_JAL:        begin is_branch = 1'b1; cond = 1'b1; tgt_sel = TGT_JUMP; end
            OP_BAL, OP_B:        begin is_branch = 1'b1; cond = 1'b1; end
            OP_BGEZAL, OP_BGEZ:  begin is_branch = 1'b1; cond = !a_neg; end
            OP_BLTZ, OP_BLTZAL:  begin is_branch = 1'b1; cond = a_neg; end
            OP_BEQ:              begin is_branch = 1'b1; cond = (i_bpu_A == i_bpu_B); end
            OP_BNE:              begin is_branch = 1'b1; cond = (i_bpu_A != i_bpu_B); end
            OP_BLEZ:             begin is_branch = 1'b1; cond = a_neg || a_zero; end
            OP_BGTZ:             begin is_branch = 1'b1; cond = !a_neg && !a_zero; end
            default:             begin is_branch = 1'b0; cond = 1'b0; end
        endcase
    end

    logic [PC_W-1:0] jump_target;
    logic [PC_W-1:0] branch_offset;
    logic [PC_W-1:0] br_target;

    assign jump_target   = {i_bpu_ex_pcnext[PC_W-1:28], i_bpu_target, 2'b00};
    assign branch_offset = {{(PC_W-18){i_bpu_target[15]}}, i_bpu_target[15:0], 2'b00};

    always_comb begin
        br_target = i_bpu_ex_pcnext + branch_offset;
        case (tgt_sel)
            TGT_JUMP: br_target = jump_target;
            TGT_REG:  br_target = i_bpu_A;
            default:  br_target = i_bpu_ex_pcnext + branch_offset;
        endcase
    end

    // A bubble or non-branch counts as "not taken", so a stale taken prediction on it still redirects.
    logic            resolved;
    logic            taken;
    logic            mispredict;
    logic [PC_W-1:0] next_pc;

    assign resolved   = i_bpu_valid && is_branch;
    assign taken      = resolved && cond;
    assign mispredict = (taken != i_bpu_ex_pred_taken) ||
                        (taken && (br_target != i_bpu_ex_pred_target));
    assign next_pc    = taken ? br_target : i_bpu_ex_pcnext;

    logic [IDX-1:0]   ex_idx;
    logic [TAG_W-1:0] ex_tag;
    logic             ex_hit;

    assign ex_idx = i_bpu_ex_pc[IDX+1:2];
    assign ex_tag = i_bpu_ex_pc[PC_W-1:IDX+2];
    assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

    // NOTE: sequential state is written only with non-blocking assignments so every read sees pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
            // NOTE: the BTB is reset explicitly; a stale valid bit after reset would produce bogus predictions.
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                tag_q[i]   <= '0;
                tgt_q[i]   <= '0;
                ctr_q[i]   <= CTR_WEAK_NT;
            end
        end else begin
            redirect_q <= mispredict;
            if (mispredict) begin
                redirect_pc_q <= next_pc;
            end
            if (resolved) begin
                if (ex_hit) begin
                    if (taken) begin
                        if (ctr_q[ex_idx] != CTR_MAX) begin
                            ctr_q[ex_idx] <= ctr_q[ex_idx] + 1'b1;
                        end
                        tgt_q[ex_idx] <= br_target;
                    end else if (ctr_q[ex_idx] != '0) begin
                        ctr_q[ex_idx] <= ctr_q[ex_idx] - 1'b1;
                    end
                end else if (taken) begin
                    valid_q[ex_idx] <= 1'b1;
                    tag_q[ex_idx]   <= ex_tag;
                    tgt_q[ex_idx]   <= br_target;
                    ctr_q[ex_idx]   <= CTR_WEAK_T;
                end
            end
        end
    end

    assign o_bpu_redirect    = redirect_q;
    assign o_bpu_clr         = redirect_q;
    assign o_bpu_redirect_PC = redirect_pc_q;

`ifdef BPU_PERF_CNT_EN
    logic [31:0] br_cnt_q;
    logic [31:0] miss_cnt_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            br_cnt_q   <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (resolved && (br_cnt_q != '1)) begin
                br_cnt_q <= br_cnt_q + 32'd1;
            end
            if (mispredict && (miss_cnt_q != '1)) begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign o_bpu_br_cnt   = br_cnt_q;
    assign o_bpu_miss_cnt = miss_cnt_q;
`endif

    // Word-aligned PCs: the byte-offset bits carry no information here.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{i_bpu_if_pc[1:0], i_bpu_ex_pc[1:0]};

endmodule

// File: tb/tb_branch_predict_unit.sv
// Self-checking bench for branch_predict_unit: directed vector table, reset corner case,
// and randomized traffic compared against a behavioural BTB/branch model.
module tb_branch_predict_unit;

    localparam int PC_W    = 32;
    localparam int ENTRIES = 16;
    localparam int TAG_SH  = 6;   // 2 byte-offset bits + log2(ENTRIES)

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        valid;
    logic [3:0]  br_op;
    logic [31:0] op_a, op_b;
    logic [25:0] target;
    logic [31:0] ex_pc, ex_pcnext;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        clr;
`ifdef BPU_PERF_CNT_EN
    logic [31:0] br_cnt, miss_cnt;
`endif

    always #5 clk = ~clk;

    branch_predict_unit #(.ENTRIES(ENTRIES), .CTR_BITS(2), .PC_W(PC_W)) dut (
        .i_clk                (clk),
        .i_rst                (rst),
`ifdef BPU_PERF_CNT_EN
        .o_bpu_br_cnt         (br_cnt),
        .o_bpu_miss_cnt       (miss_cnt),
`endif
        .i_bpu_if_pc          (if_pc),
        .o_bpu_pred_taken     (pred_taken),
        .o_bpu_pred_target    (pred_target),
        .i_bpu_valid          (valid),
        .i_bpu_brOP           (br_op),
        .i_bpu_A              (op_a),
        .i_bpu_B              (op_b),
        .i_bpu_target         (target),
        .i_bpu_ex_pc          (ex_pc),
        .i_bpu_ex_pcnext      (ex_pcnext),
        .i_bpu_ex_pred_taken  (ex_pred_taken),
        .i_bpu_ex_pred_target (ex_pred_target),
        .o_bpu_redirect       (redirect),
        .o_bpu_redirect_PC    (redirect_pc),
        .o_bpu_clr            (clr)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [25:0] t, input logic [31:0] pc, input logic p, input logic [31:0] pt);
        valid          = v;
        br_op          = op;
        op_a           = a;
        op_b           = b;
        target         = t;
        ex_pc          = pc;
        ex_pcnext      = pc + 32'd4;
        ex_pred_taken  = p;
        ex_pred_target = pt;
    endtask

    // Directed vectors: EX inputs, expected registered outputs, then an IF lookup after the update.
    typedef struct {
        logic        v;
        logic [3:0]  op;
        logic [31:0] a, b;
        logic [25:0] t;
        logic [31:0] pc;
        logic        p;
        logic [31:0] pt;
        logic        exp_redir;
        logic [31:0] exp_pc;
        logic [31:0] look_pc;
        logic        exp_ptaken;
        logic [31:0] exp_ptgt;
    } vec_t;

    function automatic vec_t mk(input logic v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                input logic [25:0] t, input logic [31:0] pc, input logic p, input logic [31:0] pt,
                                input logic er, input logic [31:0] epc, input logic [31:0] lpc,
                                input logic ept, input logic [31:0] eptg);
        vec_t r;
        r.v = v; r.op = op; r.a = a; r.b = b; r.t = t; r.pc = pc; r.p = p; r.pt = pt;
        r.exp_redir = er; r.exp_pc = epc; r.look_pc = lpc; r.exp_ptaken = ept; r.exp_ptgt = eptg;
        return r;
    endfunction

    // Behavioural model: BTB as plain arrays, counters as integers in 0..3.
    bit          m_valid [ENTRIES];
    logic [31:0] m_tag   [ENTRIES];
    logic [31:0] m_tgt   [ENTRIES];
    int          m_ctr   [ENTRIES];
    logic [31:0] m_redir_pc;

    function automatic void m_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i] = 1'b0; m_tag[i] = '0; m_tgt[i] = '0; m_ctr[i] = 1;
        end
        m_redir_pc = '0;
    endfunction

    function automatic void m_lookup(input logic [31:0] pc, output logic t, output logic [31:0] tg);
        int i;
        i  = int'((pc >> 2) % ENTRIES);
        t  = m_valid[i] && (m_tag[i] == (pc >> TAG_SH)) && (m_ctr[i] >= 2);
        tg = t ? m_tgt[i] : 32'h0;
    endfunction

    function automatic void m_resolve(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                      input logic [25:0] t, input logic [31:0] pcnext,
                                      output bit is_br, output bit tk, output logic [31:0] tgt);
        int          sa;
        int          off;
        logic [15:0] off16;
        sa    = $signed(a);
        off16 = t[15:0];
        off   = int'($signed(off16));
        is_br = (op >= 4'd1) && (op <= 4'd13);
        tgt   = pcnext + 32'(off * 4);
        case (op)
            4'd1:        begin tk = 1; tgt = a; end
            4'd2, 4'd3:  begin tk = 1; tgt = (pcnext & 32'hF000_0000) | ({6'b0, t} << 2); end
            4'd4, 4'd9:  tk = 1;
            4'd5, 4'd7:  tk = (sa >= 0);
            4'd6, 4'd8:  tk = (sa < 0);
            4'd10:       tk = (a == b);
            4'd11:       tk = (a != b);
            4'd12:       tk = (sa <= 0);
            4'd13:       tk = (sa > 0);
            default:     tk = 0;
        endcase
    endfunction

    function automatic void m_update(input logic [31:0] pc, input bit tk, input logic [31:0] tgt);
        int i;
        i = int'((pc >> 2) % ENTRIES);
        if (m_valid[i] && m_tag[i] == (pc >> TAG_SH)) begin
            if (tk) begin
                m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
                m_tgt[i] = tgt;
            end else begin
                m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
            end
        end else if (tk) begin
            m_valid[i] = 1'b1; m_tag[i] = pc >> TAG_SH; m_tgt[i] = tgt; m_ctr[i] = 2;
        end
    endfunction

    function automatic logic [31:0] pick_pc();
        logic [31:0] pool [8];
        pool = '{32'h100, 32'h140, 32'h180, 32'h104, 32'h200, 32'hA000_0000, 32'hFFFF_FFF8, 32'h3C};
        return pool[$urandom_range(0, 7)];
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'h1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    vec_t vecs [17];

    initial begin
        vecs[0]  = mk(1, 10, 5, 5, 26'h0004, 32'h100, 0, 0, 1, 32'h114, 32'h100, 1, 32'h114);
        vecs[1]  = mk(1, 10, 5, 6, 26'h0004, 32'h100, 1, 32'h114, 1, 32'h104, 32'h100, 0, 0);
        vecs[2]  = mk(1, 10, 5, 5, 26'h0004, 32'h100, 0, 0, 1, 32'h114, 32'h100, 1, 32'h114);
        vecs[3]  = mk(1, 10, 5, 5, 26'h0004, 32'h100, 1, 32'h114, 0, 32'h114, 32'h100, 1, 32'h114);
        vecs[4]  = mk(1, 10, 5, 5, 26'h0004, 32'h100, 1, 32'h114, 0, 32'h114, 32'h100, 1, 32'h114);
        vecs[5]  = mk(1, 10, 5, 5, 26'h0004, 32'h100, 1, 32'h114, 0, 32'h114, 32'h100, 1, 32'h114);
        vecs[6]  = mk(1, 10, 1, 2, 26'h0004, 32'h100, 1, 32'h114, 1, 32'h104, 32'h100, 1, 32'h114);
        vecs[7]  = mk(1, 1, 32'h8000, 0, 26'h0, 32'h204, 1, 32'h4000, 1, 32'h8000, 32'h204, 1, 32'h8000);
        vecs[8]  = mk(1, 2, 0, 0, 26'h3FF_FFFF, 32'hA000_0000, 0, 0, 1, 32'hAFFF_FFFC, 32'h100, 0, 0);
        vecs[9]  = mk(1, 10, 0, 0, 26'h0008, 32'h140, 0, 0, 1, 32'h164, 32'h140, 1, 32'h164);
        vecs[10] = mk(1, 10, 1, 0, 26'h0008, 32'h100, 0, 0, 0, 32'h164, 32'h140, 1, 32'h164);
        vecs[11] = mk(1, 6, 32'h8000_0000, 0, 26'hFFFC, 32'h308, 0, 0, 1, 32'h2FC, 32'h308, 1, 32'h2FC);
        vecs[12] = mk(1, 13, 0, 0, 26'h0010, 32'h30C, 0, 0, 0, 32'h2FC, 32'h30C, 0, 0);
        vecs[13] = mk(1, 14, 0, 0, 26'h0010, 32'h310, 0, 0, 0, 32'h2FC, 32'h310, 0, 0);
        vecs[14] = mk(1, 15, 0, 0, 26'h0010, 32'h314, 1, 32'h1234, 1, 32'h318, 32'h314, 0, 0);
        vecs[15] = mk(0, 10, 3, 3, 26'h0010, 32'h318, 0, 0, 0, 32'h318, 32'h318, 0, 0);
        vecs[16] = mk(1, 9, 0, 0, 26'h0001, 32'hFFFF_FFF8, 0, 0, 1, 32'h0, 32'hFFFF_FFF8, 1, 32'h0);

        rst   = 1'b1;
        if_pc = '0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tick;
        tick;
        check("reset_redirect", {31'b0, redirect}, 32'h0);
        check("reset_clr", {31'b0, clr}, 32'h0);
        check("reset_redirect_pc", redirect_pc, 32'h0);
        if_pc = 32'h100;
        #1;
        check("reset_pred_taken", {31'b0, pred_taken}, 32'h0);
        check("reset_pred_target", pred_target, 32'h0);
`ifdef BPU_PERF_CNT_EN
        check("reset_br_cnt", br_cnt, 32'h0);
        check("reset_miss_cnt", miss_cnt, 32'h0);
`endif
        rst = 1'b0;

        for (int i = 0; i < $size(vecs); i++) begin
            drive(vecs[i].v, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].t, vecs[i].pc, vecs[i].p, vecs[i].pt);
            tick;
            check($sformatf("vec%0d_redirect", i), {31'b0, redirect}, {31'b0, vecs[i].exp_redir});
            check($sformatf("vec%0d_clr", i), {31'b0, clr}, {31'b0, vecs[i].exp_redir});
            check($sformatf("vec%0d_redirect_pc", i), redirect_pc, vecs[i].exp_pc);
            if_pc = vecs[i].look_pc;
            #1;
            check($sformatf("vec%0d_pred_taken", i), {31'b0, pred_taken}, {31'b0, vecs[i].exp_ptaken});
            check($sformatf("vec%0d_pred_target", i), pred_target, vecs[i].exp_ptgt);
`ifdef BPU_PERF_CNT_EN
            if (i == 1) begin
                check("perf_br_cnt", br_cnt, 32'd2);
                check("perf_miss_cnt", miss_cnt, 32'd2);
            end
`endif
        end

        // Reset lands on the redirect cycle while a taken branch would also allocate: reset must win.
        drive(0, 0, 0, 0, 0, 32'h500, 1, 32'h0);
        tick;
        check("pre_rst_redirect", {31'b0, redirect}, 32'h1);
        check("pre_rst_redirect_pc", redirect_pc, 32'h504);
        rst = 1'b1;
        drive(1, 10, 7, 7, 26'h0004, 32'h400, 0, 0);
        tick;
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        check("rst_redirect", {31'b0, redirect}, 32'h0);
        check("rst_clr", {31'b0, clr}, 32'h0);
        check("rst_redirect_pc", redirect_pc, 32'h0);
        foreach (vecs[i]) begin
            if (i == 0 || i == 7 || i == 9 || i == 11 || i == 16) begin
                if_pc = vecs[i].look_pc;
                #1;
                check($sformatf("rst_miss_%08h", vecs[i].look_pc), {31'b0, pred_taken}, 32'h0);
            end
        end
        if_pc = 32'h400;
        #1;
        check("rst_beats_alloc", {31'b0, pred_taken}, 32'h0);
`ifdef BPU_PERF_CNT_EN
        check("rst_br_cnt", br_cnt, 32'h0);
        check("rst_miss_cnt", miss_cnt, 32'h0);
`endif

        // Randomized traffic against the behavioural model, starting from the reset state.
        m_reset();
        for (int n = 0; n < 400; n++) begin
            logic [31:0] pc, a, b, pt, mtgt, lk_tgt;
            logic [3:0]  op;
            logic        v, p, lk_t;
            logic [25:0] t;
            bit          is_br, tk, mis;

            pc = pick_pc();
            op = 4'($urandom_range(0, 15));
            v  = ($urandom_range(0, 9) != 0);
            a  = pick_operand();
            b  = ($urandom_range(0, 2) == 0) ? a : pick_operand();
            t  = 26'($urandom);
            if ($urandom_range(0, 3) != 0) begin
                m_lookup(pc, p, pt);
            end else begin
                p  = 1'($urandom_range(0, 1));
                pt = p ? pick_pc() : 32'h0;
            end
            drive(v, op, a, b, t, pc, p, pt);
            if_pc = pick_pc();
            #1;
            m_lookup(if_pc, lk_t, lk_tgt);
            check("rand_pred_taken", {31'b0, pred_taken}, {31'b0, lk_t});
            check("rand_pred_target", pred_target, lk_tgt);

            m_resolve(op, a, b, t, pc + 32'd4, is_br, tk, mtgt);
            tk  = tk && is_br && v;
            mis = (tk != p) || (tk && (mtgt != pt));
            if (mis) m_redir_pc = tk ? mtgt : pc + 32'd4;
            tick;
            check("rand_redirect", {31'b0, redirect}, {31'b0, mis});
            check("rand_clr", {31'b0, clr}, {31'b0, mis});
            check("rand_redirect_pc", redirect_pc, m_redir_pc);
            if (is_br && v) m_update(pc, tk, mtgt);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
